sync_fifo_flagged: RTL and testbench

//  Single-clock, parametrised-depth FIFO. Successor to the dual-clock FIFO for

---
 rtl/sync_fifo_flagged.sv | 111 +++++++++++
 tb/tb_sync_fifo_flagged.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with arbitrary depth, fill level, programmable almost-full/empty
// thresholds, overflow/underflow pulses and a selectable first-word-fall-through read port.
module sync_fifo_flagged #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int AF_THRESH  = 6,
   parameter int AE_THRESH  = 2,
   parameter int FWFT       = 0,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  W_INC,
   input  logic [DATA_WIDTH-1:0] WR_DATA,
   input  logic                  R_INC,
   output logic [DATA_WIDTH-1:0] RD_DATA,
   output logic                  RD_VALID,
   output logic                  FULL,
   output logic                  EMPTY,
   output logic                  ALMOST_FULL,
   output logic                  ALMOST_EMPTY,
   output logic [CW-1:0]         FILL_LEVEL,
   output logic                  OVERFLOW,
   output logic                  UNDERFLOW
);

   localparam int              PW       = $clog2(DEPTH);
   localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0]   AF_C     = CW'(AF_THRESH);
   localparam logic [CW-1:0]   AE_C     = CW'(AE_THRESH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic full, empty, wr_acc, rd_acc;

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      wr_acc      = W_INC & ~full;
      rd_acc      = R_INC & ~empty;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      overflow_d  = W_INC & full;
      underflow_d = R_INC & empty;
      count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);

      // Pointers wrap explicitly because DEPTH need not be a power of two.
      if (wr_acc) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
      end
      if (rd_acc) begin
         rd_ptr_d   = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
         rd_data_d  = mem_q[rd_ptr_q];
         rd_valid_d = (FWFT == 0);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; count and pointers define what is valid.
   always_ff @(posedge CLK) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q] <= WR_DATA;
      end
   end

   assign FILL_LEVEL   = count_q;
   assign FULL         = full;
   assign EMPTY        = empty;
   assign ALMOST_FULL  = (count_q >= AF_C);
   assign ALMOST_EMPTY = (count_q <= AE_C);
   assign OVERFLOW     = overflow_q;
   assign UNDERFLOW    = underflow_q;

   // In fall-through mode the head entry is presented directly from the array.
   assign RD_DATA  = (FWFT != 0) ? (empty ? '0 : mem_q[rd_ptr_q]) : rd_data_q;
   assign RD_VALID = (FWFT != 0) ? ~empty : rd_valid_q;

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Bench for sync_fifo_flagged: one registered-read and one fall-through instance share
// stimulus; a queue-based reference model feeds a scoreboard checked on the falling edge.
module tb_sync_fifo_flagged;

   localparam int DW    = 8;
   localparam int DEPTH = 5;
   localparam int AF    = 4;
   localparam int AE    = 1;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          w_inc = 1'b0;
   logic          r_inc = 1'b0;
   logic [DW-1:0] wr_data = '0;

   logic [DW-1:0] rd_data0, rd_data1;
   logic          rd_valid0, rd_valid1, full0, full1, empty0, empty1;
   logic          af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
   logic [CW-1:0] fill0, fill1;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] model_q[$];
   logic [DW-1:0] exp_rd_q[$];
   logic          exp_valid = 1'b0;
   logic          exp_ovf = 1'b0;
   logic          exp_unf = 1'b0;
   logic [DW-1:0] last_rd = '0;
   bit            mon_en = 1'b0;

   sync_fifo_flagged #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_dut0 (
      .CLK(clk), .RST(rst), .W_INC(w_inc), .WR_DATA(wr_data), .R_INC(r_inc),
      .RD_DATA(rd_data0), .RD_VALID(rd_valid0), .FULL(full0), .EMPTY(empty0),
      .ALMOST_FULL(af0), .ALMOST_EMPTY(ae0), .FILL_LEVEL(fill0),
      .OVERFLOW(ovf0), .UNDERFLOW(unf0)
   );

   sync_fifo_flagged #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_dut1 (
      .CLK(clk), .RST(rst), .W_INC(w_inc), .WR_DATA(wr_data), .R_INC(r_inc),
      .RD_DATA(rd_data1), .RD_VALID(rd_valid1), .FULL(full1), .EMPTY(empty1),
      .ALMOST_FULL(af1), .ALMOST_EMPTY(ae1), .FILL_LEVEL(fill1),
      .OVERFLOW(ovf1), .UNDERFLOW(unf1)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      model_q.delete();
      exp_rd_q.delete();
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
      last_rd   = '0;
   endtask

   // Reference model: a queue of at most DEPTH entries, updated at each active edge.
   always @(posedge clk) begin
      if (rst) begin
         clear_model();
      end else begin
         bit was_full, was_empty, wacc, racc;
         was_full  = (model_q.size() == DEPTH);
         was_empty = (model_q.size() == 0);
         wacc      = w_inc && !was_full;
         racc      = r_inc && !was_empty;
         exp_ovf   = w_inc && was_full;
         exp_unf   = r_inc && was_empty;
         exp_valid = racc;
         if (racc) exp_rd_q.push_back(model_q.pop_front());
         if (wacc) model_q.push_back(wr_data);
      end
   end

   // Monitor: compares both instances against the model between active edges.
   always @(negedge clk) begin
      if (mon_en) begin
         int n;
         logic [DW-1:0] exp_d;
         n = model_q.size();
         check("fill0",   fill0,  n);
         check("full0",   full0,  n == DEPTH);
         check("empty0",  empty0, n == 0);
         check("afull0",  af0,    n >= AF);
         check("aempty0", ae0,    n <= AE);
         check("ovf0",    ovf0,   exp_ovf);
         check("unf0",    unf0,   exp_unf);
         check("rd_valid0", rd_valid0, exp_valid);
         if (rd_valid0) begin
            if (exp_rd_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rd_data0_unexpected: got %0h, expected no read data at %0t", rd_data0, $time);
            end else begin
               exp_d = exp_rd_q.pop_front();
               check("rd_data0", rd_data0, exp_d);
               last_rd = exp_d;
            end
         end else begin
            check("rd_hold0", rd_data0, last_rd);
         end
         check("fill1",     fill1,     n);
         check("ovf1",      ovf1,      exp_ovf);
         check("unf1",      unf1,      exp_unf);
         check("rd_valid1", rd_valid1, n != 0);
         check("rd_data1",  rd_data1,  (n != 0) ? model_q[0] : '0);
      end
   end

   task automatic drive(input logic w, input logic [DW-1:0] d, input logic r);
      @(negedge clk);
      w_inc   = w;
      wr_data = d;
      r_inc   = r;
   endtask

   initial begin
      #1 rst = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Fill to full, then one rejected write.
      for (int i = 1; i <= 6; i++) drive(1'b1, DW'(i * 8'h11), 1'b0);
      drive(1'b0, '0, 1'b0);

      // Drain, then one rejected read.
      repeat (6) drive(1'b0, '0, 1'b1);
      repeat (2) drive(1'b0, '0, 1'b0);

      // Pointer wrap: 3 in / 3 out, four rounds.
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 3; i++) drive(1'b1, DW'($urandom), 1'b0);
         for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1);
      end
      drive(1'b0, '0, 1'b0);

      // Full with both requests, then empty with both requests.
      for (int i = 0; i < 5; i++) drive(1'b1, DW'(8'h30 + i), 1'b0);
      drive(1'b1, 8'h77, 1'b1);
      drive(1'b0, '0, 1'b0);
      repeat (4) drive(1'b0, '0, 1'b1);
      drive(1'b1, 8'h88, 1'b1);
      drive(1'b0, '0, 1'b0);
      drive(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b0);

      // Randomized traffic with alternating fill/drain bias.
      for (int p = 0; p < 6; p++) begin
         int wb;
         wb = (p % 2 == 0) ? 70 : 30;
         repeat (300) drive($urandom_range(0, 99) < wb, DW'($urandom), $urandom_range(0, 99) < (100 - wb));
      end

      // Fall-through visibility of a single word, then async reset mid-burst.
      repeat (6) drive(1'b0, '0, 1'b1);
      drive(1'b1, 8'hA5, 1'b0);
      drive(1'b0, '0, 1'b0);
      drive(1'b1, 8'hB1, 1'b0);
      drive(1'b1, 8'hB2, 1'b1);
      drive(1'b1, 8'hB3, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      clear_model();
      #1;
      check("rst_fill0",     fill0,     0);
      check("rst_empty0",    empty0,    1);
      check("rst_full0",     full0,     0);
      check("rst_afull0",    af0,       0);
      check("rst_aempty0",   ae0,       1);
      check("rst_rd_data0",  rd_data0,  0);
      check("rst_rd_valid0", rd_valid0, 0);
      check("rst_ovf0",      ovf0,      0);
      check("rst_unf0",      unf0,      0);
      check("rst_rd_data1",  rd_data1,  0);
      check("rst_rd_valid1", rd_valid1, 0);
      check("rst_fill1",     fill1,     0);
      w_inc = 1'b0;
      r_inc = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Post-reset sanity traffic.
      for (int i = 0; i < 4; i++) drive(1'b1, DW'(8'hC0 + i), 1'b0);
      repeat (5) drive(1'b0, '0, 1'b1);
      repeat (2) drive(1'b0, '0, 1'b0);

      @(posedge clk);
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
